// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG pixel path.
// Holds the framer state encoding, the channel-conversion mode codes and the
// fixed-point luma coefficients (Y = (77R + 150G + 29B) >> 8).
package jpeg_pkg;

  typedef enum logic [1:0] {
    FRAMER_FILL  = 2'd0,
    FRAMER_PRIME = 2'd1,
    FRAMER_DRAIN = 2'd2
  } framer_state_e;

  localparam int MODE_LUMA   = 0;
  localparam int MODE_RED    = 1;
  localparam int MODE_BINARY = 2;

  localparam logic [15:0] LUMA_COEF_R = 16'd77;
  localparam logic [15:0] LUMA_COEF_G = 16'd150;
  localparam logic [15:0] LUMA_COEF_B = 16'd29;

endpackage

// File: rtl/jpeg_pixel_framer_if.sv
// Bus between the jpeg_core pixel stream, the framer and the classifier input.
// slave  : framer side (consumes pixels, produces framed output).
// master : environment side (drives pixels, flush and output accept).
// Signals: in_valid/in_accept handshake with x/y/r/g/b payload, flush,
// out_valid/out_accept handshake with data/last, drop counter and idle flag.
interface jpeg_pixel_framer_if;
  logic        in_valid_i;
  logic        in_accept_o;
  logic [15:0] in_x_i;
  logic [15:0] in_y_i;
  logic [7:0]  in_r_i;
  logic [7:0]  in_g_i;
  logic [7:0]  in_b_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_accept_i;
  logic [7:0]  out_data_o;
  logic        out_last_o;
  logic [15:0] drop_cnt_o;
  logic        idle_o;

  modport slave (
    input  in_valid_i, in_x_i, in_y_i, in_r_i, in_g_i, in_b_i, flush_i, out_accept_i,
    output in_accept_o, out_valid_o, out_data_o, out_last_o, drop_cnt_o, idle_o
  );

  modport master (
    output in_valid_i, in_x_i, in_y_i, in_r_i, in_g_i, in_b_i, flush_i, out_accept_i,
    input  in_accept_o, out_valid_o, out_data_o, out_last_o, drop_cnt_o, idle_o
  );
endinterface

// File: rtl/rgb_to_luma.sv
// Combinational RGB -> luma converter.
// Ports: r_i/g_i/b_i 8-bit colour in, y_o 8-bit luma out.
// The weighted sum peaks at 256*255 = 65280, so 16 bits never overflow.
module rgb_to_luma
  import jpeg_pkg::*;
(
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);
  logic [15:0] sum;

  always_comb begin
    sum = LUMA_COEF_R * {8'd0, r_i} + LUMA_COEF_G * {8'd0, g_i} + LUMA_COEF_B * {8'd0, b_i};
  end

  assign y_o = 8'(sum >> 8);
endmodule

// File: rtl/jpeg_pixel_framer.sv
// Collects scattered (MCU-order) pixels into a FRAME_W x FRAME_H window buffer,
// converts each pixel to one channel on write, then streams the window out in
// raster order once every window pixel has been written.
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport): pixel input
// handshake, flush, output handshake with data/last, drop counter, idle flag.
module jpeg_pixel_framer
  import jpeg_pkg::*;
#(
  parameter int FRAME_W = 28,
  parameter int FRAME_H = 28,
  parameter int MODE    = 0,
  parameter int THRESH  = 128
)(
  input  logic                clk_i,
  input  logic                rst_i,
  jpeg_pixel_framer_if.slave  bus
);
  localparam int N  = FRAME_W * FRAME_H;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  framer_state_e state_q, state_d;
  logic [N-1:0]  written_q;
  logic [CW-1:0] fill_cnt_q, fill_cnt_d;
  logic [15:0]   drop_cnt_q;
  logic [AW-1:0] rd_addr_q;
  logic [7:0]    rd_data_q;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q;
  logic          accept_q, accept_d;
  logic          idle_q, idle_d;
  logic [7:0]    mem [N];

  logic          in_win, in_hs, wr_en, new_px, out_hs, last_hs, clear, rd_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    luma, px_val;

  rgb_to_luma u_luma (
    .r_i (bus.in_r_i),
    .g_i (bus.in_g_i),
    .b_i (bus.in_b_i),
    .y_o (luma)
  );

  always_comb begin
    px_val = luma;
    if (MODE == MODE_RED)         px_val = bus.in_r_i;
    else if (MODE == MODE_BINARY) px_val = (luma >= 8'(THRESH)) ? 8'd1 : 8'd0;
  end

  // y*FRAME_W+x < N whenever the pixel is in the window, so modulo-2^AW
  // arithmetic yields the exact address.
  assign in_win  = (bus.in_x_i < 16'(FRAME_W)) && (bus.in_y_i < 16'(FRAME_H));
  assign wr_addr = AW'(bus.in_y_i) * AW'(FRAME_W) + AW'(bus.in_x_i);
  assign in_hs   = bus.in_valid_i & accept_q;
  assign wr_en   = in_hs & in_win & ~bus.flush_i;
  assign new_px  = wr_en & ~written_q[wr_addr];
  assign out_hs  = out_valid_q & bus.out_accept_i;
  assign last_hs = out_hs & out_last_q;
  assign clear   = bus.flush_i | last_hs;
  // Read-ahead: PRIME fetches address 0, every non-final output handshake
  // fetches the next one, so DRAIN never bubbles and stalls hold the data.
  assign rd_en   = (state_q == FRAMER_PRIME) | (out_hs & ~out_last_q);

  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (clear)       fill_cnt_d = '0;
    else if (new_px) fill_cnt_d = fill_cnt_q + 1'b1;
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= FRAMER_FILL;
      accept_q    <= 1'b0;
      idle_q      <= 1'b1;
      out_valid_q <= 1'b0;
      fill_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      accept_q    <= accept_d;
      idle_q      <= idle_d;
      out_valid_q <= out_valid_d;
      fill_cnt_q  <= fill_cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = FRAMER_FILL;
    end else begin
      case (state_q)
        FRAMER_FILL:  if (new_px && fill_cnt_q == CW'(N - 1)) state_d = FRAMER_PRIME;
        FRAMER_PRIME: state_d = FRAMER_DRAIN;
        FRAMER_DRAIN: if (last_hs) state_d = FRAMER_FILL;
        default:      state_d = FRAMER_FILL;
      endcase
    end
  end

  // FSM: outputs, decoded from the next state so they come out registered
  always_comb begin
    accept_d    = (state_d == FRAMER_FILL);
    idle_d      = (state_d == FRAMER_FILL) && (fill_cnt_d == '0);
    out_valid_d = (state_d == FRAMER_DRAIN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      written_q <= '0;
    end else if (wr_en) begin
      written_q[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (in_hs && !in_win && !bus.flush_i && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      rd_addr_q  <= '0;
      out_last_q <= 1'b0;
    end else if (rd_en) begin
      rd_addr_q  <= rd_addr_q + 1'b1;
      out_last_q <= (rd_addr_q == AW'(N - 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= px_val;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)      rd_data_q <= 8'd0;
    else if (rd_en) rd_data_q <= mem[rd_addr_q];
  end

  assign bus.in_accept_o = accept_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = rd_data_q;
  assign bus.out_last_o  = out_last_q;
  assign bus.drop_cnt_o  = drop_cnt_q;
  assign bus.idle_o      = idle_q;
endmodule

// File: doc/jpeg_pixel_framer.md
# jpeg_pixel_framer

- Collects the scattered pixel stream from `jpeg_core` (MCU order, arbitrary frame size) into a parametrised FRAME_W×FRAME_H window buffer.
- Converts each pixel to a single channel according to MODE.
- Once every window pixel has been written, streams the frame out in raster order with a valid/accept handshake.
- Sits between `jpeg_core` and the classifier input. It replaces ad-hoc 28×28 collection in benches and software.

## Interface
Parameters:
- FRAME_W, 28, window width in pixels (1..256)
- FRAME_H, 28, window height in pixels (1..256)
- MODE, 0, 0 = luma, 1 = red channel, 2 = binary threshold
- THRESH, 128, threshold on luma for MODE 2

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- in_valid_i  in  1  input pixel valid
- in_accept_o  out  1  framer ready for an input pixel
- in_x_i  in  16  pixel x (matches `outport_pixel_x_o`)
- in_y_i  in  16  pixel y
- in_r_i / in_g_i / in_b_i  in  8 each  pixel colour
- flush_i  in  1  abort current frame, clear buffer
- out_valid_o  out  1  output pixel valid
- out_accept_i  in  1  downstream accepts output pixel
- out_data_o  out  8  converted pixel value
- out_last_o  out  1  marks pixel (FRAME_W-1, FRAME_H-1)
- drop_cnt_o  out  16  saturating count of out-of-window pixels
- idle_o  out  1  in FILL state with no pixels written

## Operation
- States are FILL, PRIME and DRAIN.
- **FILL**
  - in_accept_o = 1.
  - Input handshake = in_valid_i & in_accept_o.
  - A pixel with x < FRAME_W and y < FRAME_H is written to the buffer at address y*FRAME_W + x, and its bit in a FRAME_W*FRAME_H written-bitmap is set.
  - A pixel outside the window is accepted and discarded. drop_cnt_o increments and saturates at 0xFFFF.
  - A duplicate coordinate overwrites the stored data and does not advance the fill count.
  - FILL → PRIME on the handshake that sets the last clear bitmap bit.
- **PRIME**
  - in_accept_o = 0.
  - One cycle that reads address 0.
  - PRIME → DRAIN.
- **DRAIN**
  - in_accept_o = 0.
  - out_valid_o = 1. Pixels are emitted at addresses 0..N-1 (N = FRAME_W*FRAME_H), one per output handshake.
  - On the handshake with out_last_o = 1: clear the bitmap and go to FILL.
- **Conversion**
  - Applied on write.
  - Luma Y = (77R + 150G + 29B) >> 8, computed in a 16-bit sum; the maximum 65280 fits without overflow.
  - MODE 1 gives out = R.
  - MODE 2 gives out = 8'd1 if Y ≥ THRESH, else 8'd0.
- **flush_i**
  - From any state, the next state is FILL with the bitmap cleared and out_valid_o = 0.
  - drop_cnt_o is kept.
  - An input pixel handshaked in the same cycle as flush_i is discarded.
- **rst_i** clears everything, including drop_cnt_o. A reset mid-drain abandons the frame.

## Timing
- Reset values:
  - in_accept_o = 0, out_valid_o = 0, out_data_o = 0, out_last_o = 0
  - drop_cnt_o = 0, idle_o = 1
  - state = FILL
- in_accept_o rises in the first cycle after rst_i deasserts.
- The first out_valid_o is asserted 2 cycles after the completing input handshake: one PRIME cycle, then DRAIN.
- Throughput in DRAIN is 1 pixel/cycle while out_accept_i = 1. The implementation uses a read-ahead buffer, and DRAIN contains no bubbles.
- While out_valid_o = 1 and out_accept_i = 0, out_data_o and out_last_o hold stable.
- in_accept_o is 0 from the completing handshake cycle + 1 until the cycle after the last output handshake.
- Output signals are registered. in_accept_o is a registered state decode and has no combinational path from in_valid_i.

## Structure
- The shared package `jpeg_pkg` holds:
  - framer state enum (FILL/PRIME/DRAIN)
  - MODE encodings
  - luma coefficients (77/150/29)
- Sub-module `rgb_to_luma`: combinational, 3×8-bit in, 8-bit Y out, shared with other consumers.
- The buffer is an inferred single-port-write/single-port-read RAM of N×8 with registered read.

## Test plan
- **In-order fill, MODE 0:** 28×28 raster, R=G=B=x+y → 784 outputs in raster order with out_data_o = x+y, out_last_o only on (27,27), first valid 2 cycles after the last input.
- **MCU-order fill with duplicates and out-of-window pixels:** 32×32 image in 8×8 block order, pixel (5,5) sent twice (second value 0xAA) → drop_cnt_o = 240, drain starts only after all 784 window pixels, (5,5) reads 0xAA.
- **MODE 2, THRESH=128:** R=G=B=127 → out 0; R=G=B=129 → out 1. Pure red 255 → Y=76 → out 0.
- **Backpressure:** out_accept_i toggled 1,0,0,1 pseudo-randomly → data held stable while stalled, no pixel lost or duplicated, in_accept_o stays 0 until the last handshake.
- **flush_i mid-DRAIN at pixel 100:** → out_valid_o = 0 next cycle, in_accept_o = 1, a fresh full frame drains correctly, drop_cnt_o retained.
- **rst_i mid-FILL:** after 300 pixels → all outputs return to reset values, and the next frame needs all 784 pixels before draining.
